// File: rtl/rv32i_mem_pkg.sv
// Shared types and constants for the unified instruction/data memory port.
package rv32i_mem_pkg;

  localparam int DMCTRL_W = 3;
  localparam logic [DMCTRL_W-1:0] DMCTRL_WORD = 3'b010;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_DM = 2'd1,
    WAIT_IF = 2'd2
  } arb_state_t;

endpackage

// File: rtl/sat_counter.sv
// Free-running event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one memory port between fetch and data accesses, data first, and
// generates pipeline stalls. Stall counters are built only with MEM_ARB_PERF_CNT_EN.
module mem_port_arbiter
  import rv32i_mem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  input  logic                if_kill,
  output logic                if_valid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [DMCTRL_W-1:0] dm_ctrl,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  output logic                dm_valid,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [DMCTRL_W-1:0] mem_ctrl,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                stall_f,
  output logic                stall_m,
  output logic [31:0]         perf_if_stall_cnt,
  output logic [31:0]         perf_dm_stall_cnt
);

  arb_state_t        state_q, state_d;
  logic              kill_pend_q, kill_pend_d;
  logic              resp_q, resp_d;
  logic              if_valid_q, if_valid_d;
  logic              dm_valid_q, dm_valid_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;

  always_comb begin
    state_d     = state_q;
    kill_pend_d = kill_pend_q;
    resp_d      = 1'b0;
    if_valid_d  = 1'b0;
    dm_valid_d  = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_ctrl    = '0;
    mem_addr    = '0;
    mem_wdata   = '0;

    unique case (state_q)
      IDLE: begin
        // The IDLE cycle right after a response is the requester's consume
        // cycle: its request is still up, so issuing here would duplicate it.
        if (!resp_q && !reset) begin
          if (dm_req) begin
            mem_req   = 1'b1;
            mem_we    = dm_we;
            mem_ctrl  = dm_ctrl;
            mem_addr  = dm_addr;
            mem_wdata = dm_wdata;
            if (mem_gnt) state_d = WAIT_DM;
          end else if (if_req && !if_kill) begin
            mem_req  = 1'b1;
            mem_ctrl = DMCTRL_WORD;
            mem_addr = if_addr;
            if (mem_gnt) state_d = WAIT_IF;
          end
        end
      end
      WAIT_DM: begin
        if (mem_rvalid) begin
          dm_rdata_d = mem_rdata;
          dm_valid_d = 1'b1;
          resp_d     = 1'b1;
          state_d    = IDLE;
        end
      end
      WAIT_IF: begin
        kill_pend_d = kill_pend_q | if_kill;
        if (mem_rvalid) begin
          resp_d      = 1'b1;
          kill_pend_d = 1'b0;
          state_d     = IDLE;
          if (!(kill_pend_q || if_kill)) begin
            if_rdata_d = mem_rdata;
            if_valid_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      kill_pend_q <= 1'b0;
      resp_q      <= 1'b0;
      if_valid_q  <= 1'b0;
      dm_valid_q  <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      kill_pend_q <= kill_pend_d;
      resp_q      <= resp_d;
      if_valid_q  <= if_valid_d;
      dm_valid_q  <= dm_valid_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
    end
  end

  assign if_valid = if_valid_q;
  assign if_rdata = if_rdata_q;
  assign dm_valid = dm_valid_q;
  assign dm_rdata = dm_rdata_q;

  assign stall_m = dm_req & ~dm_valid_q;
  assign stall_f = (if_req & ~if_valid_q) | stall_m;

`ifdef MEM_ARB_PERF_CNT_EN
  sat_counter #(.WIDTH(32)) u_if_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_f & ~stall_m),
    .count (perf_if_stall_cnt)
  );

  sat_counter #(.WIDTH(32)) u_dm_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_m),
    .count (perf_dm_stall_cnt)
  );
`else
  assign perf_if_stall_cnt = '0;
  assign perf_dm_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed, table-driven bench for mem_port_arbiter plus reset and counter sequences.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, if_kill, if_valid;
  logic [31:0] if_addr, if_rdata;
  logic        dm_req, dm_we, dm_valid;
  logic [2:0]  dm_ctrl;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [2:0]  mem_ctrl;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        stall_f, stall_m;
  logic [31:0] perf_if_stall_cnt, perf_dm_stall_cnt;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk               (clk),
    .reset             (reset),
    .if_req            (if_req),
    .if_addr           (if_addr),
    .if_kill           (if_kill),
    .if_valid          (if_valid),
    .if_rdata          (if_rdata),
    .dm_req            (dm_req),
    .dm_we             (dm_we),
    .dm_ctrl           (dm_ctrl),
    .dm_addr           (dm_addr),
    .dm_wdata          (dm_wdata),
    .dm_valid          (dm_valid),
    .dm_rdata          (dm_rdata),
    .mem_req           (mem_req),
    .mem_we            (mem_we),
    .mem_ctrl          (mem_ctrl),
    .mem_addr          (mem_addr),
    .mem_wdata         (mem_wdata),
    .mem_gnt           (mem_gnt),
    .mem_rvalid        (mem_rvalid),
    .mem_rdata         (mem_rdata),
    .stall_f           (stall_f),
    .stall_m           (stall_m),
    .perf_if_stall_cnt (perf_if_stall_cnt),
    .perf_dm_stall_cnt (perf_dm_stall_cnt)
  );

  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_kill;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_we;
    logic        e_if_valid;
    logic [31:0] e_if_rdata;
    logic        e_dm_valid;
    logic [31:0] e_dm_rdata;
    logic        e_stall_f;
    logic        e_stall_m;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic ir, input logic [31:0] ia, input logic ik,
                     input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dd,
                     input logic g, input logic rv, input logic [31:0] rd,
                     input logic er, input logic [31:0] ea, input logic ew,
                     input logic eiv, input logic [31:0] eid, input logic edv, input logic [31:0] edd,
                     input logic esf, input logic esm);
    vec_t v;
    v.if_req = ir; v.if_addr = ia; v.if_kill = ik;
    v.dm_req = dr; v.dm_we = dw; v.dm_addr = da; v.dm_wdata = dd;
    v.gnt = g; v.rvalid = rv; v.rdata = rd;
    v.e_req = er; v.e_addr = ea; v.e_we = ew;
    v.e_if_valid = eiv; v.e_if_rdata = eid; v.e_dm_valid = edv; v.e_dm_rdata = edd;
    v.e_stall_f = esf; v.e_stall_m = esm;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask

  task automatic idle_inputs();
    if_req = 1'b0; if_addr = '0; if_kill = 1'b0;
    dm_req = 1'b0; dm_we = 1'b0; dm_ctrl = 3'b000; dm_addr = '0; dm_wdata = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] C = 32'hCAFE_F00D;
  localparam logic [31:0] K = 32'h2222_2222;
  localparam logic [31:0] S = 32'hA5A5_5A5A;

  initial begin
    logic [2:0]  exp_ctrl;
    logic [31:0] exp_perf_dm;

    reset = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    #7;
    chk("rst.mem_req",  32'(mem_req),  32'd0);
    chk("rst.if_valid", 32'(if_valid), 32'd0);
    chk("rst.dm_valid", 32'(dm_valid), 32'd0);
    chk("rst.if_rdata", if_rdata, 32'd0);
    chk("rst.dm_rdata", dm_rdata, 32'd0);
    chk("rst.stall_f",  32'(stall_f),  32'd0);
    chk("rst.perf_dm",  perf_dm_stall_cnt, 32'd0);
    next_cycle();

    // Fetch only
    add(1,32'h40,0, 0,0,0,0, 1,0,0,             1,32'h40,0, 0,0,            0,0, 1,0);
    add(1,32'h40,0, 0,0,0,0, 0,0,0,             0,0,0,      0,0,            0,0, 1,0);
    add(1,32'h40,0, 0,0,0,0, 0,1,32'h00500093,  0,0,0,      0,0,            0,0, 1,0);
    add(1,32'h40,0, 0,0,0,0, 0,0,0,             0,0,0,      1,32'h00500093, 0,0, 0,0);
    add(0,0,0,      0,0,0,0, 0,0,0,             0,0,0,      0,32'h00500093, 0,0, 0,0);
    // Simultaneous fetch and load: data first, fetch after the consume cycle
    add(1,32'h44,0, 1,0,32'h100,0, 1,0,0,            1,32'h100,0, 0,32'h00500093, 0,0, 1,1);
    add(1,32'h44,0, 1,0,32'h100,0, 0,1,C,            0,0,0,       0,32'h00500093, 0,0, 1,1);
    add(1,32'h44,0, 1,0,32'h100,0, 1,0,0,            0,0,0,       0,32'h00500093, 1,C, 1,0);
    add(1,32'h44,0, 0,0,0,0,       1,0,0,            1,32'h44,0,  0,32'h00500093, 0,C, 1,0);
    add(1,32'h44,0, 0,0,0,0,       0,1,32'h11111111, 0,0,0,       0,32'h00500093, 0,C, 1,0);
    add(0,0,0,      0,0,0,0,       0,0,0,            0,0,0,       1,32'h11111111, 0,C, 0,0);
    // Kill while in flight, then refetch from the new address
    add(1,32'h80,0,  0,0,0,0, 1,0,0,            1,32'h80,0,  0,32'h11111111, 0,C, 1,0);
    add(1,32'h80,1,  0,0,0,0, 0,0,0,            0,0,0,       0,32'h11111111, 0,C, 1,0);
    add(1,32'h200,0, 0,0,0,0, 0,1,32'hDEADBEEF, 0,0,0,       0,32'h11111111, 0,C, 1,0);
    add(1,32'h200,0, 0,0,0,0, 1,0,0,            0,0,0,       0,32'h11111111, 0,C, 1,0);
    add(1,32'h200,0, 0,0,0,0, 1,0,0,            1,32'h200,0, 0,32'h11111111, 0,C, 1,0);
    add(1,32'h200,0, 0,0,0,0, 0,1,K,            0,0,0,       0,32'h11111111, 0,C, 1,0);
    add(0,0,0,       0,0,0,0, 0,0,0,            0,0,0,       1,K,            0,C, 0,0);
    // Kill in IDLE blocks issue; kill coincident with the response drops it
    add(1,32'h300,1, 0,0,0,0, 1,0,0,            0,0,0,        0,K, 0,C, 1,0);
    add(1,32'h300,0, 0,0,0,0, 1,0,0,            1,32'h300,0,  0,K, 0,C, 1,0);
    add(1,32'h300,1, 0,0,0,0, 0,1,32'h33333333, 0,0,0,        0,K, 0,C, 1,0);
    add(0,0,0,       0,0,0,0, 0,0,0,            0,0,0,        0,K, 0,C, 0,0);
    // Store under grant backpressure: request stable for 5 cycles
    for (int n = 0; n < 4; n++)
      add(0,0,0, 1,1,32'h104,S, 0,0,0, 1,32'h104,1, 0,K, 0,C, 1,1);
    add(0,0,0, 1,1,32'h104,S, 1,0,0,            1,32'h104,1, 0,K, 0,C, 1,1);
    add(0,0,0, 1,1,32'h104,S, 0,0,0,            0,0,0,       0,K, 0,C, 1,1);
    add(0,0,0, 1,1,32'h104,S, 0,1,32'h12345678, 0,0,0,       0,K, 0,C, 1,1);
    add(0,0,0, 1,1,32'h104,S, 0,0,0,            0,0,0,       0,K, 1,32'h12345678, 0,0);
    add(0,0,0, 0,0,0,0,       0,0,0,            0,0,0,       0,K, 0,32'h12345678, 0,0);

    foreach (vecs[i]) begin
      if_req = vecs[i].if_req; if_addr = vecs[i].if_addr; if_kill = vecs[i].if_kill;
      dm_req = vecs[i].dm_req; dm_we = vecs[i].dm_we;
      dm_ctrl = vecs[i].dm_we ? 3'b001 : 3'b100;
      dm_addr = vecs[i].dm_addr; dm_wdata = vecs[i].dm_wdata;
      mem_gnt = vecs[i].gnt; mem_rvalid = vecs[i].rvalid; mem_rdata = vecs[i].rdata;
      #7;
      chk($sformatf("v%0d.mem_req", i), 32'(mem_req), 32'(vecs[i].e_req));
      if (vecs[i].e_req) begin
        exp_ctrl = vecs[i].dm_req ? dm_ctrl : 3'b010;
        chk($sformatf("v%0d.mem_addr", i), mem_addr, vecs[i].e_addr);
        chk($sformatf("v%0d.mem_we", i), 32'(mem_we), 32'(vecs[i].e_we));
        chk($sformatf("v%0d.mem_ctrl", i), 32'(mem_ctrl), 32'(exp_ctrl));
        if (vecs[i].e_we) chk($sformatf("v%0d.mem_wdata", i), mem_wdata, vecs[i].dm_wdata);
      end
      chk($sformatf("v%0d.if_valid", i), 32'(if_valid), 32'(vecs[i].e_if_valid));
      chk($sformatf("v%0d.if_rdata", i), if_rdata, vecs[i].e_if_rdata);
      chk($sformatf("v%0d.dm_valid", i), 32'(dm_valid), 32'(vecs[i].e_dm_valid));
      chk($sformatf("v%0d.dm_rdata", i), dm_rdata, vecs[i].e_dm_rdata);
      chk($sformatf("v%0d.stall_f", i), 32'(stall_f), 32'(vecs[i].e_stall_f));
      chk($sformatf("v%0d.stall_m", i), 32'(stall_m), 32'(vecs[i].e_stall_m));
      $display("vec %0d: req=%0b addr=%h if_v=%0b dm_v=%0b sf=%0b sm=%0b",
               i, mem_req, mem_addr, if_valid, dm_valid, stall_f, stall_m);
      next_cycle();
    end

    // Reset while in WAIT_DM, then a stale response after reset
    idle_inputs();
    dm_req = 1'b1; dm_ctrl = 3'b010; dm_addr = 32'h108; mem_gnt = 1'b1;
    #7 chk("rwd.issue", 32'(mem_req), 32'd1);
    next_cycle();
    idle_inputs();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h9999_9999;
    #7;
    chk("rwd.mem_req",  32'(mem_req),  32'd0);
    chk("rwd.if_rdata", if_rdata, 32'd0);
    chk("rwd.dm_rdata", dm_rdata, 32'd0);
    chk("rwd.dm_valid", 32'(dm_valid), 32'd0);
    chk("rwd.stall_m",  32'(stall_m),  32'd0);
    next_cycle();
    mem_rvalid = 1'b0; mem_rdata = '0;
    if_req = 1'b1; if_addr = 32'h400; mem_gnt = 1'b1;
    #7;
    chk("rwd.late_dm_valid", 32'(dm_valid), 32'd0);
    chk("rwd.late_dm_rdata", dm_rdata, 32'd0);
    chk("rwd.idle_issue",    32'(mem_req), 32'd1);
    chk("rwd.idle_addr",     mem_addr, 32'h400);
    $display("reset-in-wait_dm: stale response ignored, req=%0b", mem_req);
    next_cycle();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h4444_4444;
    next_cycle();
    idle_inputs();
    #7;
    chk("rwd.if_valid", 32'(if_valid), 32'd1);
    chk("rwd.if_rdata2", if_rdata, 32'h4444_4444);
    next_cycle();

    // Six-cycle load stall for the counters
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    next_cycle();
    dm_req = 1'b1; dm_ctrl = 3'b010; dm_addr = 32'h10C;
    for (int c = 0; c < 6; c++) begin
      mem_gnt    = (c == 2);
      mem_rvalid = (c == 5);
      mem_rdata  = (c == 5) ? 32'h5555_AAAA : 32'h0;
      #7 chk($sformatf("perf.stall_m%0d", c), 32'(stall_m), 32'd1);
      next_cycle();
    end
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
`ifdef MEM_ARB_PERF_CNT_EN
    exp_perf_dm = 32'd6;
`else
    exp_perf_dm = 32'd0;
`endif
    #7;
    chk("perf.dm_valid", 32'(dm_valid), 32'd1);
    chk("perf.dm_rdata", dm_rdata, 32'h5555_AAAA);
    chk("perf.dm_cnt",   perf_dm_stall_cnt, exp_perf_dm);
    chk("perf.if_cnt",   perf_if_stall_cnt, 32'd0);
    $display("perf load: dm_cnt=%0d if_cnt=%0d", perf_dm_stall_cnt, perf_if_stall_cnt);
    next_cycle();
    idle_inputs();
    next_cycle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
